// File: rtl/word_xfer_ctrl.sv
// word_xfer_ctrl
//   Moves one 16-bit word between the 8-bit memory bus and a byte-writable
//   register pair (PC, SP, pointer). The transfer is two byte accesses, one at
//   base and one at base+1 (modulo 2^ADDR_W).
//   Loads steer mem_rdata into the pair through lo_we/hi_we. Stores drive the
//   selected byte of reg_q onto mem_wdata.
//
//   Build option: define WXC_BIG_ENDIAN_EN so that the first byte (base) is
//   the high byte. By default the word is little-endian, so base holds the
//   low byte.
//
// Ports
//   clk, reset          clock and asynchronous active-low reset
//   start, op_store     request pulse and direction (1 = store);
//                       sampled only when idle
//   base_addr           address of the first byte
//   reg_q               current register pair value (store source)
//   reg_din, lo_we,     byte and write enables to the register pair
//   hi_we
//   mem_addr, mem_rd,   byte bus request
//   mem_wr, mem_wdata
//   mem_rdata,          byte bus response
//   mem_ready
//   busy, done, err     status; done pulses for one cycle, and err
//                       qualifies it (1 = timeout abort)
//
// state | meaning
// IDLE  | waiting for start; done/err reported here
// BYTE0 | first byte access at base
// BYTE1 | second byte access at base+1
module word_xfer_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_q,
   output logic [7:0]        reg_din,
   output logic              lo_we,
   output logic              hi_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BYTE0 = 2'd1;
   localparam logic [1:0] S_BYTE1 = 2'd2;

`ifdef WXC_BIG_ENDIAN_EN
   localparam logic FIRST_IS_HI = 1'b1;
`else
   localparam logic FIRST_IS_HI = 1'b0;
`endif

   // The abort fires on the miss cycle that would bring the count up to
   // TIMEOUT_CYC, so the strobe is held for exactly TIMEOUT_CYC waits.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

   logic [1:0]        state;
   logic              op_r;
   logic [ADDR_W-1:0] base_r;
   logic [7:0]        wait_cnt;
   logic              done_r;
   logic              err_r;

   logic              byte_cycle;
   logic              cur_hi;
   logic              timeout_hit;

   assign byte_cycle  = (state == S_BYTE0) || (state == S_BYTE1);
   assign cur_hi      = (state == S_BYTE1) ^ FIRST_IS_HI;
   assign timeout_hit = byte_cycle && !mem_ready && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         op_r     <= 1'b0;
         base_r   <= '0;
         wait_cnt <= 8'd0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_r     <= op_store;
                  base_r   <= base_addr;
                  wait_cnt <= 8'd0;
                  err_r    <= 1'b0;
                  state    <= S_BYTE0;
               end
            end
            S_BYTE0, S_BYTE1: begin
               if (mem_ready) begin
                  wait_cnt <= 8'd0;
                  if (state == S_BYTE0) begin
                     state <= S_BYTE1;
                  end else begin
                     state  <= S_IDLE;
                     done_r <= 1'b1;
                     err_r  <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  // A byte already written to the pair stays written.
                  state  <= S_IDLE;
                  done_r <= 1'b1;
                  err_r  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus outputs decode straight from state, so an asynchronous reset drops
   // every strobe and write enable immediately.
   always_comb begin
      mem_addr = '0;
      if (state == S_BYTE0) mem_addr = base_r;
      else if (state == S_BYTE1) mem_addr = base_r + ADDR_W'(1);
   end

   assign mem_rd    = byte_cycle && !op_r;
   assign mem_wr    = byte_cycle && op_r;
   assign mem_wdata = mem_wr ? (cur_hi ? reg_q[15:8] : reg_q[7:0]) : 8'h00;

   // Write enables follow mem_ready in the same cycle, so the pair captures
   // mem_rdata on the handshake edge.
   assign reg_din = mem_rdata;
   assign lo_we   = mem_rd && mem_ready && !cur_hi;
   assign hi_we   = mem_rd && mem_ready && cur_hi;

   assign busy = (state != S_IDLE);
   assign done = done_r;
   assign err  = err_r;

endmodule

// File: tb/tb_word_xfer_ctrl.sv
module tb_word_xfer_ctrl;

   localparam int TMO = 15;
`ifdef WXC_BIG_ENDIAN_EN
   localparam bit BIG = 1'b1;
`else
   localparam bit BIG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start, op_store;
   logic [15:0] base_addr;
   logic [15:0] reg_q;
   logic [7:0]  reg_din;
   logic        lo_we, hi_we;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        busy, done, err;

   logic [15:0] pair;
   logic [15:0] pair_val;
   logic        pair_load;

   int total = 0;
   int bad   = 0;

   word_xfer_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .op_store(op_store),
      .base_addr(base_addr), .reg_q(reg_q), .reg_din(reg_din),
      .lo_we(lo_we), .hi_we(hi_we), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Register pair fed by the controller's byte write enables.
   always @(posedge clk) begin
      if (pair_load) pair <= pair_val;
      else begin
         if (lo_we) pair[7:0]  <= reg_din;
         if (hi_we) pair[15:8] <= reg_din;
      end
   end
   assign reg_q = pair;

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic bit is_hi(input int b);
      return BIG ? (b == 0) : (b == 1);
   endfunction

   // Transaction-level reference: the word completes byte by byte, and a
   // byte that waits TMO or more cycles aborts the rest.
   function automatic void model(input logic op, input logic [15:0] rv,
                                 input int d0, input int d1,
                                 input logic [7:0] r0, input logic [7:0] r1,
                                 output logic [15:0] ep, output logic ee,
                                 output int ec);
      int dl[2];
      logic [7:0] rd[2];
      dl[0] = d0; dl[1] = d1; rd[0] = r0; rd[1] = r1;
      ep = rv; ee = 1'b0; ec = 1;
      for (int b = 0; b < 2; b++) begin
         if (dl[b] >= TMO) begin
            ee = 1'b1;
            ec += TMO;
            break;
         end
         ec += dl[b] + 1;
         if (!op) begin
            if (is_hi(b)) ep[15:8] = rd[b];
            else ep[7:0] = rd[b];
         end
      end
   endfunction

   // Called at a falling edge. Issues start, acts as the memory responder
   // with per-byte ready delays, checks every cycle, and returns at the done
   // cycle.
   task automatic run_xfer(input logic op, input logic [15:0] base,
                           input logic [15:0] rv, input int d0, input int d1,
                           input logic [7:0] r0, input logic [7:0] r1,
                           input bit poke,
                           output logic [15:0] got_pair, output logic got_err,
                           output int got_cyc, output logic [7:0] wd0,
                           output logic [7:0] wd1, output logic [15:0] a1);
      int dl[2];
      logic [7:0] rd[2];
      int b, k, cyc, idx;
      bit fin, exp_busy, rdy;
      dl[0] = d0; dl[1] = d1; rd[0] = r0; rd[1] = r1;
      wd0 = 8'h00; wd1 = 8'h00; a1 = 16'hDEAD; got_err = 1'bx;
      start = 1'b1; op_store = op; base_addr = base;
      pair_val = rv; pair_load = 1'b1; mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      pair_load = 1'b0;
      b = 0; k = 0; cyc = 0; fin = 1'b0;
      while (!fin && cyc < 80) begin
         cyc++;
         start = 1'b0;
         mem_ready = 1'b0;
         mem_rdata = 8'($urandom);
         exp_busy = (b < 2) && (k < TMO);
         idx = (b > 1) ? 1 : b;
         rdy = 1'b0;
         if (!done) begin
            rdy = exp_busy && (k == dl[idx]);
            mem_ready = rdy;
            if (exp_busy) mem_rdata = rd[idx];
            if (poke && cyc == 2) begin
               start = 1'b1; op_store = ~op; base_addr = ~base;
            end
         end
         #1;
         if (cyc == 1) begin
            chk1("busy_after_start", busy, 1'b1);
            chk1("err_cleared_by_start", err, 1'b0);
         end
         if (done) begin
            fin = 1'b1;
            got_err = err;
            chk1("busy_in_done", busy, 1'b0);
            chk1("rd_in_done", mem_rd, 1'b0);
            chk1("wr_in_done", mem_wr, 1'b0);
         end else begin
            chk1("busy", busy, exp_busy);
            chk1("mem_rd", mem_rd, exp_busy && !op);
            chk1("mem_wr", mem_wr, exp_busy && op);
            chk1("lo_we", lo_we, rdy && !op && !is_hi(idx));
            chk1("hi_we", hi_we, rdy && !op && is_hi(idx));
            if (exp_busy) begin
               chkv("mem_addr", mem_addr, base + 16'(b));
               if (op) chkv("mem_wdata", {8'h00, mem_wdata},
                            {8'h00, is_hi(b) ? rv[15:8] : rv[7:0]});
               if (b == 1 && k == 0) a1 = mem_addr;
            end
            if (rdy) begin
               if (b == 0) wd0 = mem_wdata;
               else wd1 = mem_wdata;
               b++; k = 0;
            end else begin
               k++;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      mem_ready = 1'b0;
      if (!fin) chk1("done_within_budget", 1'b0, 1'b1);
      got_pair = pair;
      got_cyc = cyc;
   endtask

   typedef struct {
      logic        op;
      logic [15:0] base, rv;
      int          d0, d1;
      logic [7:0]  r0, r1;
      logic [15:0] exp_pair;
      logic        exp_err;
      int          exp_cyc;
      bit          chk_a1;
      logic [15:0] exp_a1;
      logic [7:0]  exp_wd0, exp_wd1;
   } vec_t;

   vec_t tbl[7];

   function automatic int pick_delay();
      if ($urandom_range(0, 9) < 7) return $urandom_range(0, 3);
      return $urandom_range(13, 17);
   endfunction

   initial begin
      logic [15:0] gp, ep, ga1;
      logic ge, ee;
      int gc, ec;
      logic [7:0] gw0, gw1;
      logic op;
      logic [15:0] base, rv;
      int d0, d1;
      logic [7:0] r0, r1;

      tbl[0] = '{1'b0, 16'h1000, 16'h0000, 0, 0, 8'h34, 8'h12,
                 BIG ? 16'h3412 : 16'h1234, 1'b0, 3, 1'b1, 16'h1001, 8'h00, 8'h00};
      tbl[1] = '{1'b1, 16'hFFFF, 16'hBEEF, 2, 2, 8'h00, 8'h00,
                 16'hBEEF, 1'b0, 7, 1'b1, 16'h0000,
                 BIG ? 8'hBE : 8'hEF, BIG ? 8'hEF : 8'hBE};
      tbl[2] = '{1'b0, 16'h4000, 16'h5555, 20, 0, 8'h99, 8'h88,
                 16'h5555, 1'b1, 16, 1'b0, 16'h0000, 8'h00, 8'h00};
      tbl[3] = '{1'b0, 16'h7FFF, 16'hAAAA, 0, 15, 8'h77, 8'h66,
                 BIG ? 16'h77AA : 16'hAA77, 1'b1, 17, 1'b1, 16'h8000, 8'h00, 8'h00};
      tbl[4] = '{1'b0, 16'h0123, 16'h0000, 14, 14, 8'h01, 8'h02,
                 BIG ? 16'h0102 : 16'h0201, 1'b0, 31, 1'b1, 16'h0124, 8'h00, 8'h00};
      tbl[5] = '{1'b1, 16'h0010, 16'h1234, 0, 15, 8'h00, 8'h00,
                 16'h1234, 1'b1, 17, 1'b1, 16'h0011,
                 BIG ? 8'h12 : 8'h34, 8'h00};
      tbl[6] = '{1'b0, 16'h2000, 16'h0000, 0, 0, 8'h12, 8'h34,
                 BIG ? 16'h1234 : 16'h3412, 1'b0, 3, 1'b1, 16'h2001, 8'h00, 8'h00};

      reset = 1'b0; start = 1'b0; op_store = 1'b0; base_addr = 16'h0;
      mem_rdata = 8'h00; mem_ready = 1'b0; pair_val = 16'h0; pair_load = 1'b1;
      repeat (3) @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_rd", mem_rd, 1'b0);
      chk1("rst_wr", mem_wr, 1'b0);
      chk1("rst_lo_we", lo_we, 1'b0);
      chk1("rst_hi_we", hi_we, 1'b0);
      chkv("rst_addr", mem_addr, 16'h0000);
      chkv("rst_wdata", {8'h00, mem_wdata}, 16'h0000);
      reset = 1'b1;
      pair_load = 1'b0;
      @(negedge clk);

      // Directed vectors, each followed by an idle cycle that checks that
      // done is a single pulse and that err is held.
      for (int i = 0; i < 7; i++) begin
         run_xfer(tbl[i].op, tbl[i].base, tbl[i].rv, tbl[i].d0, tbl[i].d1,
                  tbl[i].r0, tbl[i].r1, 1'b0, gp, ge, gc, gw0, gw1, ga1);
         chkv($sformatf("v%0d_pair", i), gp, tbl[i].exp_pair);
         chk1($sformatf("v%0d_err", i), ge, tbl[i].exp_err);
         chki($sformatf("v%0d_cycles", i), gc, tbl[i].exp_cyc);
         if (tbl[i].chk_a1) chkv($sformatf("v%0d_addr1", i), ga1, tbl[i].exp_a1);
         if (tbl[i].op) begin
            chkv($sformatf("v%0d_wd0", i), {8'h00, gw0}, {8'h00, tbl[i].exp_wd0});
            if (!tbl[i].exp_err)
               chkv($sformatf("v%0d_wd1", i), {8'h00, gw1}, {8'h00, tbl[i].exp_wd1});
         end
         @(negedge clk); #1;
         chk1($sformatf("v%0d_done_pulse", i), done, 1'b0);
         chk1($sformatf("v%0d_err_hold", i), err, tbl[i].exp_err);
         @(negedge clk);
      end

      // A start while busy must be ignored: the per-cycle address checks
      // would flag a restarted transfer, and the cycle count would shift.
      run_xfer(1'b0, 16'h6000, 16'h0000, 5, 1, 8'hA1, 8'hB2, 1'b1,
               gp, ge, gc, gw0, gw1, ga1);
      chki("poke_cycles", gc, 9);
      chkv("poke_pair", gp, BIG ? 16'hA1B2 : 16'hB2A1);

      // A start in the done cycle is accepted back-to-back, and it clears a
      // timeout err.
      run_xfer(1'b0, 16'h3000, 16'h1111, 16, 0, 8'h00, 8'h00, 1'b0,
               gp, ge, gc, gw0, gw1, ga1);
      chk1("chain_a_err", ge, 1'b1);
      run_xfer(1'b1, 16'h3100, 16'hCAFE, 0, 1, 8'h00, 8'h00, 1'b0,
               gp, ge, gc, gw0, gw1, ga1);
      chk1("chain_b_err", ge, 1'b0);
      chki("chain_b_cycles", gc, 4);

      // Reset asserted during BYTE1 of a load.
      @(negedge clk);
      pair_val = 16'hC3C3; pair_load = 1'b1;
      start = 1'b1; op_store = 1'b0; base_addr = 16'h5000;
      @(negedge clk);
      start = 1'b0; pair_load = 1'b0;
      mem_ready = 1'b1; mem_rdata = 8'h11;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 8'h22;
      #1;
      chk1("rstmid_rd_before", mem_rd, 1'b1);
      chkv("rstmid_addr_before", mem_addr, 16'h5001);
      #2;
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk1("rstmid_rd", mem_rd, 1'b0);
      chk1("rstmid_wr", mem_wr, 1'b0);
      chk1("rstmid_lo_we", lo_we, 1'b0);
      chk1("rstmid_hi_we", hi_we, 1'b0);
      chk1("rstmid_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk1("idle_ready_hi_we", hi_we, 1'b0);
      chk1("idle_ready_lo_we", lo_we, 1'b0);
      @(negedge clk); #1;
      chk1("idle_ready_busy", busy, 1'b0);
      chk1("idle_ready_done", done, 1'b0);
      chkv("rstmid_pair", pair, BIG ? 16'h11C3 : 16'hC311);
      mem_ready = 1'b0;
      @(negedge clk);

      // Random transfers checked against the transaction-level model.
      for (int n = 0; n < 40; n++) begin
         op = 1'($urandom);
         base = 16'($urandom);
         rv = 16'($urandom);
         d0 = pick_delay();
         d1 = pick_delay();
         r0 = 8'($urandom);
         r1 = 8'($urandom);
         model(op, rv, d0, d1, r0, r1, ep, ee, ec);
         run_xfer(op, base, rv, d0, d1, r0, r1, 1'b0, gp, ge, gc, gw0, gw1, ga1);
         chkv($sformatf("rnd%0d_pair", n), gp, ep);
         chk1($sformatf("rnd%0d_err", n), ge, ee);
         chki($sformatf("rnd%0d_cycles", n), gc, ec);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk); #1;
            chk1($sformatf("rnd%0d_done_pulse", n), done, 1'b0);
            chk1($sformatf("rnd%0d_err_hold", n), err, ee);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
